disp_scan: RTL and testbench

Multiplexed display scanner for the cycle computer's 4-digit seven-segment display. It holds a frame of 4-bit display codes and blanks leading zeros. It time-multiplexes one digit at a time onto a shared code bus, which feeds `bcd2sev_seg`, and drives a one-hot digit-enable. Frames update only at frame boundaries, so a half-updated reading never appears on the display.

---
 rtl/disp_pkg.sv | 23 ++
 rtl/lz_blank.sv | 35 +++
 rtl/disp_scan.sv | 117 +++++++++++
 tb/tb_disp_scan.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// ============================================================================
//  disp_pkg
//  Shared display codes and scan-state encoding for the seven-segment display.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package disp_pkg;

    localparam logic [3:0] CODE_D     = 4'd10;
    localparam logic [3:0] CODE_T     = 4'd11;
    localparam logic [3:0] CODE_V     = 4'd12;
    localparam logic [3:0] CODE_C     = 4'd13;
    localparam logic [3:0] CODE_BLANK = 4'd14;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/lz_blank.sv
// ============================================================================
//  lz_blank
//  Combinational leading-zero suppression; digit 0 is never replaced.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module lz_blank
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    i_enable,
    input  logic [4*NUM_DIGITS-1:0] i_codes,
    output logic [4*NUM_DIGITS-1:0] o_codes
);

    logic w_lead;

    always_comb begin
        o_codes = i_codes;
        w_lead  = i_enable;
        // Walk from the most significant digit; the first significant code ends blanking.
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (w_lead && ((i_codes[4*k +: 4] == 4'd0) || (i_codes[4*k +: 4] == CODE_BLANK))) begin
                o_codes[4*k +: 4] = CODE_BLANK;
            end else begin
                w_lead = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/disp_scan.sv
// ============================================================================
//  disp_scan
//  Multiplexed 7-segment scanner with shadow frame and frame-boundary commit.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module disp_scan
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1024,
    parameter int BLANK_CYC  = 2
) (
    input  logic                    Clock,
    input  logic                    nReset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    blank_lz,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_start
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = 4 * NUM_DIGITS;

    localparam logic [PW-1:0] c_PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] c_BLANK_LAST = PW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] c_IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    scan_state_t           r_state;
    logic                  r_pending;
    logic [FW-1:0]         r_shadow;
    logic [FW-1:0]         r_frame;
    logic [3:0]            r_bcd_out;
    logic [NUM_DIGITS-1:0] r_digit_en;
    logic                  r_frame_start;

    logic                  w_terminal;
    logic                  w_wrap;
    logic                  w_commit;
    logic [PW-1:0]         w_presc_nxt;
    logic [IW-1:0]         w_idx_nxt;
    scan_state_t           w_state_nxt;
    logic [FW-1:0]         w_lz_frame;
    logic [FW-1:0]         w_frame_nxt;
    logic [3:0]            w_bcd_nxt;
    logic [NUM_DIGITS-1:0] w_en_nxt;

    lz_blank #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_blank (
        .i_enable (blank_lz),
        .i_codes  (r_shadow),
        .o_codes  (w_lz_frame)
    );

    assign w_terminal  = (r_presc == c_PRESC_LAST);
    assign w_wrap      = w_terminal && (r_idx == c_IDX_LAST);
    assign w_commit    = w_wrap && r_pending;
    assign w_presc_nxt = w_terminal ? '0 : r_presc + 1'b1;
    assign w_idx_nxt   = w_terminal ? (w_wrap ? '0 : r_idx + 1'b1) : r_idx;
    assign w_frame_nxt = w_commit ? w_lz_frame : r_frame;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BLANK:   w_state_nxt = (r_presc == c_BLANK_LAST) ? SHOW : BLANK;
            SHOW:    w_state_nxt = w_terminal ? BLANK : SHOW;
            default: w_state_nxt = BLANK;
        endcase
    end

    // Outputs are registered from next-state values so code and enable move on the same edge.
    assign w_bcd_nxt = w_frame_nxt[{w_idx_nxt, 2'b00} +: 4];
    assign w_en_nxt  = (w_state_nxt == SHOW) ? (NUM_DIGITS'(1) << w_idx_nxt) : '0;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_state       <= BLANK;
            r_pending     <= 1'b0;
            r_shadow      <= {NUM_DIGITS{CODE_BLANK}};
            r_frame       <= {NUM_DIGITS{CODE_BLANK}};
            r_bcd_out     <= CODE_BLANK;
            r_digit_en    <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_presc       <= w_presc_nxt;
            r_idx         <= w_idx_nxt;
            r_state       <= w_state_nxt;
            r_frame       <= w_frame_nxt;
            r_bcd_out     <= w_bcd_nxt;
            r_digit_en    <= w_en_nxt;
            r_frame_start <= w_wrap;
            // A load coinciding with a commit keeps pending so the new data lands next frame.
            if (load) begin
                r_shadow  <= digits_in;
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign bcd_out     = r_bcd_out;
    assign digit_en    = r_digit_en;
    assign frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_disp_scan.sv
// ============================================================================
//  tb_disp_scan
//  Directed self-checking bench for disp_scan (SCAN_DIV=4, BLANK_CYC=1).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_disp_scan;

    localparam int NUM_DIGITS = 4;
    localparam int SCAN_DIV   = 4;
    localparam int BLANK_CYC  = 1;

    logic        Clock;
    logic        nReset;
    logic        load;
    logic [15:0] digits_in;
    logic        blank_lz;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_en;
    logic        frame_start;

    int n_checks;
    int n_fail;

    disp_scan #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .BLANK_CYC  (BLANK_CYC)
    ) u_dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .load        (load),
        .digits_in   (digits_in),
        .blank_lz    (blank_lz),
        .bcd_out     (bcd_out),
        .digit_en    (digit_en),
        .frame_start (frame_start)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_frame(output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 40) begin
            step();
            cycles++;
            if (frame_start) seen = 1'b1;
        end
        if (!seen) chk("frame_start_timeout", 32'd0, 32'd1);
    endtask

    // Called at a frame_start sample; each digit's code is taken at the start of its dwell.
    task automatic read_frame(output logic [15:0] codes);
        codes[3:0] = bcd_out;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            repeat (SCAN_DIV) step();
            codes[4*k +: 4] = bcd_out;
        end
    endtask

    task automatic do_load(input logic [15:0] val, input logic lz);
        load      = 1'b1;
        digits_in = val;
        blank_lz  = lz;
        step();
        load      = 1'b0;
    endtask

    initial begin
        int          cyc;
        logic [15:0] fr;
        logic [3:0]  exp_en;

        n_checks  = 0;
        n_fail    = 0;
        nReset    = 1'b0;
        load      = 1'b0;
        digits_in = '0;
        blank_lz  = 1'b0;

        repeat (3) step();
        chk("rst_bcd", 32'(bcd_out), 32'd14);
        chk("rst_en", 32'(digit_en), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        nReset = 1'b1;

        // Free-running scan: 0000, 0001 x3, 0000, 0010 x3, ...; frame_start every 16 edges.
        for (int e = 1; e <= 32; e++) begin
            step();
            exp_en = ((e % 4) == 0) ? 4'b0000 : (4'b0001 << ((e / 4) % 4));
            chk($sformatf("scan_en_%0d", e), 32'(digit_en), 32'(exp_en));
            chk($sformatf("scan_fs_%0d", e), 32'(frame_start), ((e % 16) == 0) ? 32'd1 : 32'd0);
            if ((e % 8) == 3) chk($sformatf("scan_bcd_%0d", e), 32'(bcd_out), 32'd14);
        end

        // Now at edge 32 (idx3 presc0 + frame_start just seen at 32 means idx0 presc0).
        repeat (2) step();
        do_load(16'h0042, 1'b1);
        wait_frame(cyc);
        read_frame(fr);
        chk("lz_0042", 32'(fr), 32'h0000EE42);

        do_load(16'h0042, 1'b0);
        wait_frame(cyc);
        read_frame(fr);
        chk("nolz_0042", 32'(fr), 32'h00000042);

        do_load(16'h0000, 1'b1);
        wait_frame(cyc);
        read_frame(fr);
        chk("lz_zero", 32'(fr), 32'h0000EEE0);

        // Mid-frame load at idx 1: old frame must persist until the wrap.
        wait_frame(cyc);
        chk("old_d0", 32'(bcd_out), 32'd0);
        repeat (5) step();
        do_load(16'hC123, 1'b1);
        repeat (2) step();
        chk("old_d2_bcd", 32'(bcd_out), 32'd14);
        chk("old_d2_en", 32'(digit_en), 32'd0);
        step();
        chk("old_d2_en_on", 32'(digit_en), 32'b0100);
        repeat (3) step();
        chk("old_d3_bcd", 32'(bcd_out), 32'd14);
        wait_frame(cyc);
        chk("fs_period", 32'(cyc), 32'd4);
        read_frame(fr);
        chk("new_c123", 32'(fr), 32'h0000C123);

        // Load A mid-frame, then load B exactly on the wrap edge.
        do_load(16'h0005, 1'b1);
        repeat (2) step();
        do_load(16'h0987, 1'b1);
        chk("wrap_fs", 32'(frame_start), 32'd1);
        read_frame(fr);
        chk("wrap_old_shadow", 32'(fr), 32'h0000EEE5);
        wait_frame(cyc);
        read_frame(fr);
        chk("wrap_new_shadow", 32'(fr), 32'h0000E987);

        // Asynchronous reset mid-dwell with a pending load.
        do_load(16'h0111, 1'b1);
        step();
        #2;
        nReset = 1'b0;
        #1;
        chk("arst_bcd", 32'(bcd_out), 32'd14);
        chk("arst_en", 32'(digit_en), 32'd0);
        chk("arst_fs", 32'(frame_start), 32'd0);
        repeat (2) step();
        nReset = 1'b1;
        wait_frame(cyc);
        chk("arst_first_fs", 32'(cyc), 32'd16);
        read_frame(fr);
        chk("arst_no_commit", 32'(fr), 32'h0000EEEE);
        wait_frame(cyc);
        read_frame(fr);
        chk("arst_no_commit2", 32'(fr), 32'h0000EEEE);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
